mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 mux (inputs i0..i3, selects s1/s0, output z) among four requesters.
- Grants one requester at a time and drives the mux selects to that requester's index, so z carries the granted input.
- Sits directly in front of the mux instance. Purely a control block: no data passes through it.

---
 rtl/mux4_arb_pkg.sv | 22 ++
 rtl/mux4_rr_arbiter_rr_pick.sv | 27 ++
 rtl/mux4_rr_arbiter.sv | 110 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux select arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Callers guarantee a one-hot (or zero) argument, so OR-ing indices is exact.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request strictly after pointer, wrapping.
module rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Offset NUM_REQ wraps back to pointer itself, so the last holder is lowest priority.
    always_comb begin
        found = 1'b0;
        idx   = pointer;
        cand  = pointer;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = pointer + IDX_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the selects of a shared 4:1 mux.
// Optional grant tenure limit enabled by defining ARB_TIMEOUT_EN.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               s1,
    output logic               s0,
    output logic               busy,
    output logic               timeout
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255 || (64'(1) << CNT_W) <= 64'(HOLD_MAX)) begin : g_bad_cfg
        $error("mux4_rr_arbiter: HOLD_MAX/CNT_W out of range");
    end

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   sel, sel_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               busy_nxt;
    logic               timeout_nxt;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cur;
    logic               limit_hit;

    rr_pick u_pick (
        .req     (req),
        .pointer (ptr),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    assign cur = onehot_to_idx(gnt);

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    // Zero throughout IDLE so the count starts fresh on every GRANT entry.
    always_ff @(posedge clk) begin
        if (rst || state == ARB_IDLE) cnt <= '0;
        else                          cnt <= cnt + CNT_W'(1);
    end

    assign limit_hit = (cnt == CNT_W'(HOLD_MAX - 1));
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        sel_nxt     = sel;
        gnt_nxt     = gnt;
        busy_nxt    = busy;
        timeout_nxt = 1'b0;
        case (state)
            ARB_IDLE: begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (pick_found) begin
                    gnt_nxt   = NUM_REQ'(1) << pick_idx;
                    sel_nxt   = pick_idx;
                    busy_nxt  = 1'b1;
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // A dropped request wins over the limit: that is a normal release.
                if (!req[cur] || limit_hit) begin
                    gnt_nxt     = '0;
                    busy_nxt    = 1'b0;
                    ptr_nxt     = cur;
                    timeout_nxt = req[cur];
                    state_nxt   = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            ptr     <= IDX_W'(NUM_REQ - 1);
            sel     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            sel     <= sel_nxt;
            gnt     <= gnt_nxt;
            busy    <= busy_nxt;
            timeout <= timeout_nxt;
        end
    end

    assign s1 = sel[1];
    assign s0 = sel[0];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with a behavioural 4:1 mux on the selects.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       s1, s0, busy, timeout;
    logic [7:0] din [4];
    logic [7:0] z;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .s1      (s1),
        .s0      (s0),
        .busy    (busy),
        .timeout (timeout)
    );

    assign z = din[{s1, s0}];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input int sel);
        chk({tag, ".gnt"},  32'(gnt),        32'h0);
        chk({tag, ".busy"}, 32'(busy),       32'h0);
        chk({tag, ".sel"},  32'({s1, s0}),   32'(sel));
    endtask

    task automatic chk_grant(input string tag, input int k);
        chk({tag, ".gnt"},  32'(gnt),        32'(4'b0001 << k));
        chk({tag, ".busy"}, 32'(busy),       32'h1);
        chk({tag, ".sel"},  32'({s1, s0}),   32'(k));
        chk({tag, ".z"},    32'(z),          32'(8'hA0 + 8'(k)));
    endtask

    initial begin
        int order [5];
        int bad_hold;
        order = '{0, 1, 2, 3, 0};
        din[0] = 8'hA0; din[1] = 8'hA1; din[2] = 8'hA2; din[3] = 8'hA3;

        // Reset state
        step(); step();
        chk_idle("rst", 0);
        chk("rst.timeout", 32'(timeout), 32'h0);

        // Single requester, 1-cycle latency, release
        rst = 1'b0; req = 4'b0001;
        step();
        chk_grant("single", 0);
        req = 4'b0000;
        step();
        chk_idle("single_rel", 0);

        // All request: 0,1,2,3,0 from a fresh pointer of 3
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            step();
            chk_grant($sformatf("rr%0d_a", t), order[t]);
            step();
            chk_grant($sformatf("rr%0d_b", t), order[t]);
            req[order[t]] = 1'b0;
            step();
            chk_idle($sformatf("rr%0d_rel", t), order[t]);
            req = 4'b1111;
        end

        // Pointer at 3, then 1001 must wrap to 0
        req = 4'b1000;
        step();
        chk_grant("p3", 3);
        req = 4'b0000;
        step();
        chk_idle("p3_rel", 3);
        req = 4'b1001;
        step();
        chk_grant("wrap", 0);
        req = 4'b0000;
        step();
        chk_idle("wrap_rel", 0);

        // Reset mid-grant restores pointer 3
        req = 4'b0100;
        step();
        chk_grant("mid", 2);
        rst = 1'b1;
        step();
        chk_idle("mid_rst", 0);
        rst = 1'b0; req = 4'b1100;
        step();
        chk_grant("post_rst", 2);
        req = 4'b0000;
        step();
        chk_idle("post_rst_rel", 2);

        // Persistent single requester on index 1
        req = 4'b0010;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            step();
            chk_grant($sformatf("to_hold%0d", c), 1);
            chk($sformatf("to_hold%0d.timeout", c), 32'(timeout), 32'h0);
        end
        step();
        chk_idle("to_rel", 1);
        chk("to_rel.timeout", 32'(timeout), 32'h1);
        step();
        chk_grant("to_regrant", 1);
        chk("to_regrant.timeout", 32'(timeout), 32'h0);
`else
        step();
        chk_grant("hold_start", 1);
        bad_hold = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (gnt !== 4'b0010 || timeout !== 1'b0 || busy !== 1'b1) bad_hold++;
        end
        chk("hold300.bad_cycles", 32'(bad_hold), 32'h0);
        chk_grant("hold_end", 1);
        chk("hold_end.timeout", 32'(timeout), 32'h0);
`endif
        req = 4'b0000;
        step();
        chk_idle("final_rel", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
